// File: rtl/pulse_pkg.sv
// pulse_pkg: frame geometry and reader state type shared by the pulse-model BRAM
// generator, the reader and the stream stages built around them.
package pulse_pkg;

    localparam int PULSE_DEPTH       = 1024;  // frame words held in the pulse BRAM
    localparam int PULSE_ADDR_STRIDE = 4;     // byte step between consecutive words
    localparam int PULSE_WORD_W      = 32;    // pulse sample word width
    localparam int PULSE_LFSR_W      = 10;    // generator LFSR spans the 2**10-word frame

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } reader_state_e;

    // Requested frame length limited to what the BRAM can hold.
    function automatic logic [31:0] clamp_len(input logic [31:0] n, input logic [31:0] limit);
        return (n > limit) ? limit : n;
    endfunction

endpackage

// File: rtl/pulse_skid_fifo.sv
// pulse_skid_fifo: small circular FIFO for stream stages. Entries carry the
// sample word plus its last tag; the head is presented as registered state, and
// push and pop in the same cycle leave the occupancy unchanged.
module pulse_skid_fifo
    import pulse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PULSE_WORD_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    // An empty FIFO shows zero so the stream data is clean out of reset.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, so
        // the order of these statements cannot create read-after-write races.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy alone defines which
        // entries are live, and the head is masked to zero while empty.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pulse_bram_reader.sv
// pulse_bram_reader: scans the pulse frame from BRAM port B and streams each word
// on a valid/ready interface, tolerating backpressure across the read latency and
// counting non-zero words delivered.
// Build option PULSE_READER_CLEAR_EN: read-and-clear mode, where every read is
// followed next cycle by a zero write to the same address (one word per two cycles).
module pulse_bram_reader
    import pulse_pkg::*;
#(
    parameter int DEPTH       = PULSE_DEPTH,
    parameter int ADDR_STRIDE = PULSE_ADDR_STRIDE,
    parameter int RD_LATENCY  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             frame_len,
    output logic [31:0]             bram_addr,
    output logic                    bram_en,
    output logic                    bram_we,
    output logic [PULSE_WORD_W-1:0] bram_din,
    input  logic [PULSE_WORD_W-1:0] bram_dout,
    output logic [PULSE_WORD_W-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             pulse_count
);

`ifdef PULSE_READER_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    // Minimum depth that keeps one word per cycle flowing with the read latency.
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W      = $clog2(DEPTH + 1);

    reader_state_e         state, state_n;
    logic [IDX_W-1:0]      word_index;
    logic [IDX_W-1:0]      len;
    logic                  wr_phase;
    logic [RD_LATENCY-1:0] infl_v;
    logic [RD_LATENCY-1:0] infl_last;
    logic [CW-1:0]         inflight_cnt;
    logic [CW-1:0]         fifo_count;
    logic                  room;
    logic                  last_idx;
    logic                  issue_rd;
    logic                  issue_wr;
    logic                  advance;
    logic                  accept;
    logic [PULSE_WORD_W:0] head;

    assign last_idx = (word_index == len - IDX_W'(1));
    assign advance  = CLEAR_EN ? issue_wr : issue_rd;
    assign accept   = m_valid && m_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign bram_en  = issue_rd || issue_wr;
    assign bram_din = '0;
    assign bram_addr = bram_en ? 32'(word_index) * 32'(ADDR_STRIDE) : '0;
    assign m_data   = head[PULSE_WORD_W-1:0];
    assign m_last   = head[PULSE_WORD_W];

    // Reads still in flight; a new read may issue only if the FIFO can absorb all of them.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight_cnt = inflight_cnt + CW'(infl_v[i]);
        room = (CW'(FIFO_DEPTH) - fifo_count) > inflight_cnt;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state and BRAM issue decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_n  = state;
        issue_rd = 1'b0;
        issue_wr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = (frame_len == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                issue_wr = wr_phase;
                issue_rd = !wr_phase && room;
                if (advance && last_idx) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (accept && m_last) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Frame bookkeeping: latch the clamped length, walk the word index, count pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_index  <= '0;
            len         <= '0;
            pulse_count <= '0;
        end else if (state == ST_IDLE && start) begin
            word_index  <= '0;
            len         <= IDX_W'(clamp_len(frame_len, 32'(DEPTH)));
            pulse_count <= '0;
        end else begin
            if (advance) word_index <= word_index + IDX_W'(1);
            if (accept && (m_data != '0) && (pulse_count != '1))
                pulse_count <= pulse_count + 32'd1;
        end
    end

`ifdef PULSE_READER_CLEAR_EN
    // Alternate read and zero-write cycles on the same address.
    always_ff @(posedge clk) begin
        if (rst)           wr_phase <= 1'b0;
        else if (issue_rd) wr_phase <= 1'b1;
        else if (issue_wr) wr_phase <= 1'b0;
    end
    assign bram_we = issue_wr;
`else
    assign wr_phase = 1'b0;
    assign bram_we  = 1'b0;
`endif

    // In-flight tracker: marks which cycle's bram_dout is real data and whether it ends the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_v    <= '0;
            infl_last <= '0;
        end else begin
            infl_v    <= (infl_v << 1) | RD_LATENCY'(issue_rd);
            infl_last <= (infl_last << 1) | RD_LATENCY'(issue_rd && last_idx);
        end
    end

    pulse_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PULSE_WORD_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (infl_v[RD_LATENCY-1]),
        .push_data  ({infl_last[RD_LATENCY-1], bram_dout}),
        .pop        (accept),
        .head_data  (head),
        .head_valid (m_valid),
        .count      (fifo_count)
    );

endmodule

// File: doc/pulse_bram_reader.md
# pulse_bram_reader

Read side of the pulse-model BRAM: scans the pulse frame that the pulse generator writes, one word per byte-strided address, and streams each word out on a valid/ready sample interface. Sits between the pulse BRAM (port B) and downstream sample consumers such as the DAC or shaping filter. It tolerates downstream backpressure across the BRAM read latency and counts the non-zero pulse words it delivers.

## Interface
- `DEPTH`, 1024: frame words in BRAM; matches the 10-bit pulse address space.
- `ADDR_STRIDE`, 4: byte increment between consecutive word addresses.
- `RD_LATENCY`, 2: BRAM read latency in cycles, from `bram_en` to valid `bram_dout`.
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame scan; ignored while `busy`.
- `frame_len` in 32: number of words to scan; sampled on `start`.
- `bram_addr` out 32: byte address (`word_index * ADDR_STRIDE`).
- `bram_en` out 1: BRAM enable.
- `bram_we` out 1: BRAM write enable; used only by the clear feature.
- `bram_din` out 32: BRAM write data; always 0.
- `bram_dout` in 32: BRAM read data.
- `m_data` out 32: sample word.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: consumer accepts the word.
- `m_last` out 1: marks the final word of the frame.
- `busy` out 1: a scan is in progress.
- `done` out 1: one-cycle pulse when the last word is accepted.
- `pulse_count` out 32: count of non-zero words accepted in the current or last frame.

## Operation
- States:
  - IDLE. `start` with `frame_len`=0 goes to DONE. Any other `start` goes to READ.
  - READ. Issues reads. Goes to DRAIN after the last address is issued.
  - DRAIN. Waits for the in-flight reads and the FIFO to empty. Goes to DONE when the `m_last` word is accepted.
  - DONE. Pulses `done` for one cycle, then goes to IDLE.
- Clamp: `len = min(frame_len, DEPTH)`, latched on `start`. `pulse_count` clears on `start`.
- Read issue: a read is issued at `word_index` (0 .. len-1) only when the FIFO's free entries exceed the reads in flight. This guarantees data never overflows.
- Read data enters the FIFO exactly `RD_LATENCY` cycles after its issue; that delay is tracked by an in-flight shift register.
- Last-word tag: travels with the data for `word_index == len-1`.
- Output: the FIFO head drives `m_data` and `m_last`. A word leaves only on `m_valid && m_ready`.
- Accept: `pulse_count` increments on each accept with `m_data != 0`. It saturates at 0xFFFFFFFF.
- `busy` = state != IDLE.
- Start handling: `start` in READ, DRAIN or DONE is dropped, not queued.
- Simultaneous push and pop on the same cycle: legal. The FIFO occupancy is unchanged.
- Reset mid-frame:
  - State returns to IDLE and the FIFO and in-flight tracker are emptied.
  - Late `bram_dout` returns are discarded.
  - `pulse_count` is zeroed.

## Timing
- Reset values: `bram_addr`, `bram_din` and `m_data` = 0. `bram_en`, `bram_we`, `m_valid`, `m_last`, `busy` and `done` = 0. `pulse_count` = 0.
- Start cycle T: `busy`=1 at T+1, and the first `bram_en` at T+1. The first `m_valid` is at T+1+`RD_LATENCY`+1 (one registered FIFO output stage).
- Throughput: one word per cycle with `m_ready` held high.
- Backpressure: `m_valid` holds and `m_data`/`m_last` are stable until accepted. Issue stalls within one cycle of the FIFO filling.
- `done` is asserted the cycle after the `m_last` accept; `busy` falls the following cycle.
- FIFO depth: `RD_LATENCY`+2, which is the minimum depth for full throughput.

## Configuration
- `PULSE_READER_CLEAR_EN` defined: read-and-clear mode.
  - Each read at address A is followed the next cycle by `bram_en`=1, `bram_we`=1, `bram_din`=0 at A.
  - Throughput drops to one word per two cycles.
  - The BRAM port is configured read-first, so the returned data is the pre-clear value.
  - This empties the frame for the generator's next pass.
- Undefined: `bram_we` is tied 0 and no write cycles occur.

## Structure
- Shared package `pulse_pkg`:
  - state enum (IDLE/READ/DRAIN/DONE)
  - `PULSE_DEPTH`=1024, `PULSE_ADDR_STRIDE`=4, `PULSE_WORD_W`=32
  - the LFSR width constant, so the generator and the reader agree on frame geometry
- Sub-module `pulse_skid_fifo`:
  - parameterised depth, 33-bit entries (data plus last tag), push/pop with occupancy output
  - reused by other stream stages.

## Test plan
- Reset, then `start` with `frame_len`=0: `done` pulses within 2 cycles. No `bram_en` is seen and `pulse_count` stays 0.
- Preload addresses 0,4,…,36 with 0,1,0,2,0,0,3,0,0,4; `frame_len`=10, `m_ready`=1:
  - 10 words arrive in order, back to back.
  - `m_last` is set on the 10th word, and `pulse_count`=4.
- Same frame with `m_ready` toggled 1-0-0-1 at random: no word is lost or duplicated, and data is stable while stalled.
- `frame_len`=5000: exactly 1024 reads occur (addresses 0 to 4092), and `m_last` is on word 1024.
- `rst` asserted on the 3rd accepted word: every output is at its reset value next cycle. No stale `m_valid` appears afterwards, and a new `start` scans from address 0.
- With `PULSE_READER_CLEAR_EN`:
  - each read is followed by a zero write to the same address
  - the streamed data matches the preload
  - a second scan returns all zeros with `pulse_count`=0.
